// File: rtl/drac_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : drac_pkg
//  Description : Shared types for the SIMD functional-unit sequencer.
//                - instr_type_t : decoded vector op type
//                - lat_class_t  : latency class used by issue/writeback
//                - simd_lat_class() maps an op type to its latency class
//                - simd_slot_t  : one result-slot entry {valid, tag, class}
//  Revision    : 1.0  initial release
// ============================================================================
package drac_pkg;

    localparam int SIMD_TAG_W = 4;

    typedef enum logic [6:0] {
        NOP,
        VADD, VSUB, VRSUB, VAND, VOR, VXOR,
        VSLL, VSRL, VSRA,
        VMIN, VMINU, VMAX, VMAXU,
        VMSEQ, VMSNE, VMV, VREDSUM,
        VMUL, VMULH, VMULHU, VMULHSU,
        VWMUL, VWMULU, VWMULSU,
        VMADD, VNMSUB, VMACC, VNMSAC,
        VWMACC, VWMACCU, VWMACCSU, VWMACCUS,
        VDIV, VDIVU, VREM, VREMU
    } instr_type_t;

    typedef enum logic [1:0] {
        LAT_SIMPLE = 2'd0,
        LAT_MUL    = 2'd1,
        LAT_MACC   = 2'd2,
        LAT_DIV    = 2'd3
    } lat_class_t;

    typedef struct packed {
        logic                  valid;
        logic [SIMD_TAG_W-1:0] tag;
        lat_class_t            lat_class;
    } simd_slot_t;

    // Anything not explicitly a multiply, multiply-accumulate or divide
    // (including unknown encodings) goes down the single-cycle path.
    function automatic lat_class_t simd_lat_class(input instr_type_t op);
        lat_class_t cls;
        case (op)
            VMUL, VMULH, VMULHU, VMULHSU,
            VWMUL, VWMULU, VWMULSU:                    cls = LAT_MUL;
            VMADD, VNMSUB, VMACC, VNMSAC,
            VWMACC, VWMACCU, VWMACCSU, VWMACCUS:       cls = LAT_MACC;
            VDIV, VDIVU, VREM, VREMU:                  cls = LAT_DIV;
            default:                                   cls = LAT_SIMPLE;
        endcase
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simd_div_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : simd_div_tracker
//  Description : Occupancy tracker for the non-pipelined vector divider.
//                Counts down from DIV_LAT-1 after a divide starts; last_o
//                marks the cycle the divide result retires, which is also
//                the earliest cycle a following divide may start.
//  Ports       : clk_i, rst_i (async, active-high), flush_i, start_i
//                busy_o  - divider occupied
//                last_o  - final busy cycle (result retiring now)
//  Revision    : 1.0  initial release
// ============================================================================
module simd_div_tracker #(
    parameter int DIV_LAT = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic start_i,
    output logic busy_o,
    output logic last_o
);

    localparam int                CNT_W    = $clog2(DIV_LAT);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DIV_LAT - 1);

    localparam logic [0:0] D_IDLE = 1'b0;
    localparam logic [0:0] D_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= D_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. A start in the last cycle of a running divide
    // reloads the counter, giving back-to-back divides with no gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = D_IDLE;
            cnt_d   = '0;
        end else if (start_i) begin
            state_d = D_RUN;
            cnt_d   = CNT_INIT;
        end else begin
            case (state_q)
                D_RUN: begin
                    if (cnt_q == '0) begin
                        state_d = D_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = D_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy_o = (state_q == D_RUN);
        last_o = (state_q == D_RUN) && (cnt_q == '0);
    end

endmodule
`default_nettype wire

// File: rtl/simd_fu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : simd_fu_sequencer
//  Description : Issue/writeback scheduler for the SIMD functional-unit
//                lanes. Classifies each op by latency, reserves the single
//                shared result slot at issue time and emits the issue pulse
//                plus a tag-qualified select pulse in the exact cycle each
//                result is valid on the lane outputs.
//  Ports       : clk_i, rst_i (async, active-high), flush_i
//                instr_valid_i/instr_type_i/instr_tag_i  - op from RR
//                instr_ready_o                            - op accepted
//                issue_valid_o/issue_tag_o                - lane start pulse
//                sel_valid_o/sel_tag_o/sel_class_o        - writeback select
//                div_busy_o                               - divider occupied
//  Parameters  : TAG_W, MUL_LAT, DIV_LAT (DIV_LAT must exceed MUL_LAT+1)
//  Revision    : 1.0  initial release
// ============================================================================
module simd_fu_sequencer
    import drac_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             instr_valid_i,
    input  instr_type_t      instr_type_i,
    input  logic [TAG_W-1:0] instr_tag_i,
    output logic             instr_ready_o,
    output logic             issue_valid_o,
    output logic [TAG_W-1:0] issue_tag_o,
    output logic             sel_valid_o,
    output logic [TAG_W-1:0] sel_tag_o,
    output lat_class_t       sel_class_o,
    output logic             div_busy_o
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        lat_class_t       lat_class;
    } slot_t;

    // Slot index an op is written into = its latency minus one.
    localparam int IDX_SIMPLE = 0;
    localparam int IDX_MUL    = MUL_LAT - 1;
    localparam int IDX_MACC   = MUL_LAT;
    localparam int IDX_DIV    = DIV_LAT - 1;

    // Slot line: slot_q[0] is the entry retiring this cycle and is what the
    // sel_* outputs show, so they come straight from a flop.
    slot_t      slot_q [DIV_LAT];
    slot_t      slot_d [DIV_LAT];
    slot_t      w_shift[DIV_LAT];

    lat_class_t w_class;
    int         w_lat_idx;
    logic       w_slot_taken;
    logic       w_ready;
    logic       w_accept;
    logic       w_div_busy;
    logic       w_div_last;

    simd_div_tracker #(
        .DIV_LAT (DIV_LAT)
    ) u_div_tracker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .start_i (w_accept && (w_class == LAT_DIV)),
        .busy_o  (w_div_busy),
        .last_o  (w_div_last)
    );

    always_comb begin
        w_class = simd_lat_class(instr_type_i);
        case (w_class)
            LAT_MUL:  w_lat_idx = IDX_MUL;
            LAT_MACC: w_lat_idx = IDX_MACC;
            LAT_DIV:  w_lat_idx = IDX_DIV;
            default:  w_lat_idx = IDX_SIMPLE;
        endcase

        // Line contents as they will be after this cycle's shift.
        for (int k = 0; k < DIV_LAT - 1; k++) begin
            w_shift[k] = slot_q[k + 1];
        end
        w_shift[DIV_LAT - 1] = '0;

        // The op's retire cycle is already reserved if its target entry is
        // occupied once the line has moved on.
        w_slot_taken = 1'b0;
        for (int k = 0; k < DIV_LAT; k++) begin
            if (k == w_lat_idx) begin
                w_slot_taken = w_shift[k].valid;
            end
        end

        // A divide may start in the retiring cycle of the previous divide.
        w_ready  = !rst_i && !flush_i && !w_slot_taken
                   && !((w_class == LAT_DIV) && w_div_busy && !w_div_last);
        w_accept = instr_valid_i && w_ready;

        for (int k = 0; k < DIV_LAT; k++) begin
            slot_d[k] = w_shift[k];
            if (flush_i) begin
                slot_d[k].valid = 1'b0;
            end else if (w_accept && (k == w_lat_idx)) begin
                slot_d[k].valid     = 1'b1;
                slot_d[k].tag       = instr_tag_i;
                slot_d[k].lat_class = w_class;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DIV_LAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
        end
    end

    always_comb begin
        instr_ready_o = w_ready;
        issue_valid_o = w_accept;
        issue_tag_o   = instr_tag_i;
        sel_valid_o   = slot_q[0].valid;
        sel_tag_o     = slot_q[0].tag;
        sel_class_o   = slot_q[0].lat_class;
        div_busy_o    = w_div_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_simd_fu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simd_fu_sequencer
//  Description : Directed self-checking bench for simd_fu_sequencer.
//                Inputs change 1ns after the rising edge; outputs are
//                sampled on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_simd_fu_sequencer;
    import drac_pkg::*;

    localparam int TAG_W   = 4;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 20;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    instr_type_t      in_type;
    logic [TAG_W-1:0] in_tag;
    logic             ready;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             sel_valid;
    logic [TAG_W-1:0] sel_tag;
    lat_class_t       sel_class;
    logic             div_busy;

    int checks = 0;
    int errors = 0;

    // Scoreboard indexed by relative cycle for the mixed-traffic run.
    logic             exp_v [0:255];
    logic [TAG_W-1:0] exp_t [0:255];

    simd_fu_sequencer #(
        .TAG_W   (TAG_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .instr_valid_i (in_valid),
        .instr_type_i  (in_type),
        .instr_tag_i   (in_tag),
        .instr_ready_o (ready),
        .issue_valid_o (issue_valid),
        .issue_tag_o   (issue_tag),
        .sel_valid_o   (sel_valid),
        .sel_tag_o     (sel_tag),
        .sel_class_o   (sel_class),
        .div_busy_o    (div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input instr_type_t t, input logic [TAG_W-1:0] g);
        in_valid = v;
        in_type  = t;
        in_tag   = g;
    endtask

    function automatic int lat_of(input instr_type_t t);
        case (t)
            VMUL:    return MUL_LAT;
            VMACC:   return MUL_LAT + 1;
            VDIV:    return DIV_LAT;
            default: return 1;
        endcase
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic seen;
        rst = 1'b1;
        drive(1'b1, VADD, 4'd3);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++;
        if ({issue_valid, sel_valid, div_busy} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: issue/sel/busy got %b expected 000", {issue_valid, sel_valid, div_busy});
        end
        checks++;
        if (sel_tag !== 4'd0 || sel_class !== LAT_SIMPLE) begin
            errors++; $display("FAIL reset_sel_fields: tag %0d class %0d expected 0/0", sel_tag, sel_class);
        end
        tick();
        rst = 1'b0;
        drive(1'b0, VADD, 4'd0);
        tick();
        // Three ops in flight, then an asynchronous reset mid-cycle.
        drive(1'b1, VDIV, 4'd1);  tick();
        drive(1'b1, VMUL, 4'd2);  tick();
        drive(1'b1, VMACC, 4'd3); tick();
        drive(1'b0, VADD, 4'd0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ready, sel_valid, div_busy} !== 3'b000) begin
            errors++; $display("FAIL reset_async: ready/sel/busy got %b expected 000", {ready, sel_valid, div_busy});
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (sel_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_retire: sel_valid seen %b expected 0", seen); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_latency();
        instr_type_t t;
        lat_class_t  cls;
        int          l;
        logic [TAG_W-1:0] g;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       begin t = VADD;  cls = LAT_SIMPLE; l = 1; g = 4'd1; end
                1:       begin t = VMUL;  cls = LAT_MUL;    l = 2; g = 4'd2; end
                default: begin t = VMACC; cls = LAT_MACC;   l = 3; g = 4'd3; end
            endcase
            drive(1'b1, t, g);
            @(negedge clk);
            checks++;
            if ({issue_valid, issue_tag} !== {1'b1, g}) begin
                errors++; $display("FAIL lat_issue_%0d: valid/tag got %b/%0d expected 1/%0d", i, issue_valid, issue_tag, g);
            end
            tick();
            drive(1'b0, VADD, 4'd0);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                checks++;
                if (sel_valid !== (c == l)) begin
                    errors++; $display("FAIL lat_sel_%0d_c%0d: sel_valid got %b expected %b", i, c, sel_valid, (c == l));
                end
                if (c == l) begin
                    checks++;
                    if (sel_tag !== g || sel_class !== cls) begin
                        errors++; $display("FAIL lat_tag_%0d: tag/class got %0d/%0d expected %0d/%0d", i, sel_tag, sel_class, g, cls);
                    end
                end
                tick();
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_collision();
        drive(1'b1, VMUL, 4'd4);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL coll_c0_ready: got %b expected 1", ready); end
        tick();
        drive(1'b1, VADD, 4'd5);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL coll_c1_blocked: ready/issue got %b/%b expected 0/0", ready, issue_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL coll_c2_ready: got %b expected 1", ready); end
        checks++;
        if ({sel_valid, sel_tag} !== {1'b1, 4'd4}) begin
            errors++; $display("FAIL coll_c2_sel: valid/tag got %b/%0d expected 1/4", sel_valid, sel_tag);
        end
        tick();
        drive(1'b0, VADD, 4'd0);
        @(negedge clk);
        checks++;
        if ({sel_valid, sel_tag} !== {1'b1, 4'd5}) begin
            errors++; $display("FAIL coll_c3_sel: valid/tag got %b/%0d expected 1/5", sel_valid, sel_tag);
        end
        tick();
        @(negedge clk);
        checks++;
        if (sel_valid !== 1'b0) begin errors++; $display("FAIL coll_c4_idle: sel_valid got %b expected 0", sel_valid); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_div();
        logic             ev;
        logic [TAG_W-1:0] et;
        drive(1'b1, VDIV, 4'd6);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL div_c0_ready: got %b expected 1", ready); end
        tick();
        drive(1'b1, VDIV, 4'd7);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== (c == 20) || div_busy !== 1'b1) begin
                errors++; $display("FAIL div_hold_c%0d: ready/busy got %b/%b expected %b/1", c, ready, div_busy, (c == 20));
            end
            if (c == 20) begin
                checks++;
                if ({sel_valid, sel_tag, sel_class} !== {1'b1, 4'd6, LAT_DIV}) begin
                    errors++; $display("FAIL div_c20_sel: valid/tag/class got %b/%0d/%0d expected 1/6/3", sel_valid, sel_tag, sel_class);
                end
            end
            tick();
        end
        for (int c = 21; c <= 41; c++) begin
            if (c == 21)      drive(1'b1, VADD, 4'd9);
            else if (c == 22) drive(1'b1, VADD, 4'd10);
            else              drive(1'b0, VADD, 4'd0);
            @(negedge clk);
            if (c == 21 || c == 22) begin
                checks++;
                if (ready !== 1'b1) begin errors++; $display("FAIL div_vadd_c%0d: ready got %b expected 1", c, ready); end
            end
            ev = (c == 22) || (c == 23) || (c == 40);
            et = (c == 22) ? 4'd9 : (c == 23) ? 4'd10 : 4'd7;
            checks++;
            if (sel_valid !== ev || (ev && sel_tag !== et)) begin
                errors++; $display("FAIL div_sel_c%0d: valid/tag got %b/%0d expected %b/%0d", c, sel_valid, sel_tag, ev, et);
            end
            checks++;
            if (div_busy !== (c <= 40)) begin
                errors++; $display("FAIL div_busy_c%0d: got %b expected %b", c, div_busy, (c <= 40));
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        // A retiring op coincident with flush is still presented.
        drive(1'b1, VADD, 4'd15);
        tick();
        drive(1'b0, VADD, 4'd0);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if ({sel_valid, sel_tag, ready} !== {1'b1, 4'd15, 1'b0}) begin
            errors++; $display("FAIL flush_coincide: sel/tag/ready got %b/%0d/%b expected 1/15/0", sel_valid, sel_tag, ready);
        end
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (sel_valid !== 1'b0) begin errors++; $display("FAIL flush_after_coincide: sel_valid got %b expected 0", sel_valid); end
        tick();

        drive(1'b1, VDIV, 4'd11);
        tick();
        drive(1'b1, VMUL, 4'd12);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL flush_vmul_ready: got %b expected 1", ready); end
        tick();
        drive(1'b1, VADD, 4'd13);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || issue_valid !== 1'b0) begin
            errors++; $display("FAIL flush_blocks_issue: ready/issue got %b/%b expected 0/0", ready, issue_valid);
        end
        tick();
        flush = 1'b0;
        drive(1'b1, VDIV, 4'd14);
        @(negedge clk);
        checks++;
        if ({div_busy, ready, sel_valid} !== 3'b010) begin
            errors++; $display("FAIL flush_c2: busy/ready/sel got %b expected 010", {div_busy, ready, sel_valid});
        end
        tick();
        drive(1'b0, VADD, 4'd0);
        for (int c = 3; c <= 23; c++) begin
            @(negedge clk);
            checks++;
            if (sel_valid !== (c == 22) || (c == 22 && sel_tag !== 4'd14)) begin
                errors++; $display("FAIL flush_sel_c%0d: valid/tag got %b/%0d expected %b/14", c, sel_valid, sel_tag, (c == 22));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (div_busy !== 1'b0) begin errors++; $display("FAIL flush_div_done: busy got %b expected 0", div_busy); end
        tick();
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int          t;
        int          issued;
        int          last_ret;
        int          l;
        logic        pred;
        instr_type_t cur;

        // Equal-latency stream: one op per cycle, no stalls.
        for (int c = 0; c <= 10; c++) begin
            if (c < 8) drive(1'b1, VMACC, 4'(c));
            else       drive(1'b0, VADD, 4'd0);
            @(negedge clk);
            if (c < 8) begin
                checks++;
                if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c%0d: got %b expected 1", c, ready); end
            end
            checks++;
            if (sel_valid !== (c >= 3) || (c >= 3 && sel_tag !== 4'(c - 3))) begin
                errors++; $display("FAIL b2b_sel_c%0d: valid/tag got %b/%0d expected %b/%0d", c, sel_valid, sel_tag, (c >= 3), c - 3);
            end
            tick();
        end

        // Random mix with a per-cycle reservation scoreboard.
        for (int i = 0; i < 256; i++) begin
            exp_v[i] = 1'b0;
            exp_t[i] = '0;
        end
        issued   = 0;
        last_ret = 0;
        t        = 0;
        cur      = VADD;
        while (t < 200 && (issued < 32 || t <= last_ret)) begin
            if (issued < 32) drive(1'b1, cur, 4'(issued));
            else             drive(1'b0, VADD, 4'd0);
            @(negedge clk);
            l    = lat_of(cur);
            pred = !exp_v[t + l];
            if (issued < 32) begin
                checks++;
                if (ready !== pred) begin
                    errors++; $display("FAIL mix_ready_t%0d: got %b expected %b", t, ready, pred);
                end
            end
            checks++;
            if (sel_valid !== exp_v[t] || (exp_v[t] && sel_tag !== exp_t[t])) begin
                errors++; $display("FAIL mix_sel_t%0d: valid/tag got %b/%0d expected %b/%0d", t, sel_valid, sel_tag, exp_v[t], exp_t[t]);
            end
            if (issued < 32 && ready === 1'b1) begin
                exp_v[t + l] = 1'b1;
                exp_t[t + l] = 4'(issued);
                last_ret     = t + l;
                issued++;
                case ($urandom_range(2, 0))
                    0:       cur = VADD;
                    1:       cur = VMUL;
                    default: cur = VMACC;
                endcase
            end
            tick();
            t++;
        end
        checks++;
        if (issued !== 32) begin errors++; $display("FAIL mix_issued: got %0d expected 32", issued); end
        drive(1'b0, VADD, 4'd0);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, VADD, 4'd0);
        test_reset();
        test_latency();
        test_collision();
        test_div();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
